// File: rtl/lsu_initiator.sv
`default_nettype none
// ============================================================================
// Module   : lsu_initiator
// Purpose  : CPU-side load/store unit. Takes one request at a time from the
//            execute stage, forms the effective address, screens it for
//            funct3 legality, alignment and address mapping, then sequences
//            a single-cycle store strobe or a one-cycle registered read on the
//            byte-lane data memory / MMIO port. It returns the load data or a
//            fault status on a valid/ready response channel.
// Ports    : clk, reset           - clock, synchronous active-high reset
//            req_*                - request channel (valid/ready, store flag,
//                                   funct3, base, offset, unshifted wdata)
//            resp_*               - response channel (valid/ready, rdata,
//                                   misaligned / illegal flags)
//            mem_*                - memory port (write strobe, funct3,
//                                   write/read address, write data, read data)
//            load_count, store_count, fault_count
//                                 - completed-response counters, present only
//                                   when LSU_PERF_CNT_EN is defined
// Options  : LSU_PERF_CNT_EN      - adds the performance counter outputs
// Revision : 1.0 - initial release
// ============================================================================
module lsu_initiator #(
    parameter int RAM_ADDR_BITS = 13
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_base,
    input  logic [31:0] req_offset,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_misaligned,
    output logic        resp_illegal,
    output logic        mem_write_mem,
    output logic [2:0]  mem_funct3,
    output logic [31:0] mem_write_address,
    output logic [31:0] mem_write_data,
    output logic [31:0] mem_read_address,
    input  logic [31:0] mem_read_data
`ifdef LSU_PERF_CNT_EN
    ,
    output logic [31:0] load_count,
    output logic [31:0] store_count,
    output logic [31:0] fault_count
`endif
);

    localparam int UPPER_W = 32 - RAM_ADDR_BITS;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        store_q, store_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mis_q, mis_d;
    logic        ill_q, ill_d;

    // Request screening, evaluated on the live request in the accept cycle
    logic [31:0]        w_addr;
    logic [UPPER_W-1:0] w_upper;
    logic               w_mapped;
    logic               w_bad_funct3;
    logic               w_misaligned;

    assign w_addr   = req_base + req_offset;
    assign w_upper  = w_addr[31:RAM_ADDR_BITS];
    // RAM sits at the bottom of the map, MMIO at the very top
    assign w_mapped = (w_upper == '0) || (&w_upper);

    // Stores only have SB/SH/SW; loads lack 011, 110 and 111
    assign w_bad_funct3 = req_store ? (req_funct3 > 3'b010)
                                    : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));

    // Width is carried in funct3[1:0] for both signed and unsigned forms
    assign w_misaligned = ((req_funct3[1:0] == 2'b10) && (w_addr[1:0] != 2'b00))
                       || ((req_funct3[1:0] == 2'b01) && w_addr[0]);

`ifdef LSU_PERF_CNT_EN
    logic [31:0] load_cnt_q, load_cnt_d;
    logic [31:0] store_cnt_q, store_cnt_d;
    logic [31:0] fault_cnt_q, fault_cnt_d;
`endif

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        store_d  = store_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        mis_d    = mis_q;
        ill_d    = ill_q;
`ifdef LSU_PERF_CNT_EN
        load_cnt_d  = load_cnt_q;
        store_cnt_d = store_cnt_q;
        fault_cnt_d = fault_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d   = w_addr;
                    funct3_d = req_funct3;
                    store_d  = req_store;
                    wdata_d  = req_wdata;
                    rdata_d  = 32'd0;
                    mis_d    = w_misaligned;
                    ill_d    = w_bad_funct3 || !w_mapped;
                    // Faulted requests skip the memory port entirely
                    if (w_misaligned || w_bad_funct3 || !w_mapped) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = store_q ? ST_RESP : ST_CAPTURE;
            end
            ST_CAPTURE: begin
                // Memory read data is valid the cycle after the address
                rdata_d = mem_read_data;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
`ifdef LSU_PERF_CNT_EN
                    if (mis_q || ill_q) begin
                        fault_cnt_d = fault_cnt_q + 32'd1;
                    end else if (store_q) begin
                        store_cnt_d = store_cnt_q + 32'd1;
                    end else begin
                        load_cnt_d = load_cnt_q + 32'd1;
                    end
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= 32'd0;
            funct3_q <= 3'd0;
            store_q  <= 1'b0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            mis_q    <= 1'b0;
            ill_q    <= 1'b0;
`ifdef LSU_PERF_CNT_EN
            load_cnt_q  <= 32'd0;
            store_cnt_q <= 32'd0;
            fault_cnt_q <= 32'd0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            store_q  <= store_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            mis_q    <= mis_d;
            ill_q    <= ill_d;
`ifdef LSU_PERF_CNT_EN
            load_cnt_q  <= load_cnt_d;
            store_cnt_q <= store_cnt_d;
            fault_cnt_q <= fault_cnt_d;
`endif
        end
    end

    assign req_ready       = (state_q == ST_IDLE);
    assign resp_valid      = (state_q == ST_RESP);
    assign resp_rdata      = rdata_q;
    assign resp_misaligned = mis_q;
    assign resp_illegal    = ill_q;

    // Gated by the raw reset so a reset landing in ISSUE cancels the write
    assign mem_write_mem     = (state_q == ST_ISSUE) && store_q && !reset;
    assign mem_funct3        = funct3_q;
    assign mem_write_address = addr_q;
    assign mem_read_address  = addr_q;
    assign mem_write_data    = wdata_q;

`ifdef LSU_PERF_CNT_EN
    assign load_count  = load_cnt_q;
    assign store_count = store_cnt_q;
    assign fault_count = fault_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lsu_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_initiator
// Purpose  : Directed self-checking bench for lsu_initiator with a byte-lane
//            RAM / MMIO memory model behind the memory port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_initiator;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_base = 32'd0;
    logic [31:0] req_offset = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic        resp_illegal;
    logic        mem_write_mem;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_write_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_address;
    logic [31:0] mem_read_data = 32'd0;
`ifdef LSU_PERF_CNT_EN
    logic [31:0] load_count;
    logic [31:0] store_count;
    logic [31:0] fault_count;
`endif

    localparam logic [31:0] C_MILLIS = 32'h0001_E240;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    logic [31:0] wr_addr = 32'd0;

    always #5 clk = ~clk;

    lsu_initiator #(.RAM_ADDR_BITS(13)) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_store         (req_store),
        .req_funct3        (req_funct3),
        .req_base          (req_base),
        .req_offset        (req_offset),
        .req_wdata         (req_wdata),
        .resp_valid        (resp_valid),
        .resp_ready        (resp_ready),
        .resp_rdata        (resp_rdata),
        .resp_misaligned   (resp_misaligned),
        .resp_illegal      (resp_illegal),
        .mem_write_mem     (mem_write_mem),
        .mem_funct3        (mem_funct3),
        .mem_write_address (mem_write_address),
        .mem_write_data    (mem_write_data),
        .mem_read_address  (mem_read_address),
        .mem_read_data     (mem_read_data)
`ifdef LSU_PERF_CNT_EN
        ,
        .load_count        (load_count),
        .store_count       (store_count),
        .fault_count       (fault_count)
`endif
    );

    // Byte-lane memory model: RAM at the bottom 8 KiB, millis at 0xFFFFFFF8
    logic [7:0] mem [0:8191];

    function automatic logic [31:0] rd_fmt(input logic [31:0] a, input logic [2:0] f3);
        logic [12:0] i0, i1, i2, i3;
        logic [31:0] w;
        if (a[31:13] == 19'h7FFFF) begin
            return (a == 32'hFFFF_FFF8) ? C_MILLIS : 32'd0;
        end
        i0 = a[12:0];
        i1 = i0 + 13'd1;
        i2 = i0 + 13'd2;
        i3 = i0 + 13'd3;
        w  = {mem[i3], mem[i2], mem[i1], mem[i0]};
        case (f3)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b100:  return {24'd0, w[7:0]};
            3'b101:  return {16'd0, w[15:0]};
            default: return w;
        endcase
    endfunction

    always @(posedge clk) begin
        if (mem_write_mem && mem_write_address[31:13] == 19'd0) begin
            mem[mem_write_address[12:0]] <= mem_write_data[7:0];
            if (mem_funct3[1:0] != 2'b00) begin
                mem[mem_write_address[12:0] + 13'd1] <= mem_write_data[15:8];
            end
            if (mem_funct3[1:0] == 2'b10) begin
                mem[mem_write_address[12:0] + 13'd2] <= mem_write_data[23:16];
                mem[mem_write_address[12:0] + 13'd3] <= mem_write_data[31:24];
            end
        end
        mem_read_data <= rd_fmt(mem_read_address, mem_funct3);
    end

    // Count write strobes mid-cycle, away from the edges
    always @(negedge clk) begin
        if (mem_write_mem) begin
            wr_cnt  = wr_cnt + 1;
            wr_addr = mem_write_address;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request and wait (bounded) for resp_valid; lat counts the
    // accept edge as cycle 1.
    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] base,
                          input logic [31:0] off, input logic [31:0] wd, output int lat);
        @(negedge clk);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_base   = base;
        req_offset = off;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic finish_resp(input string tag);
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk({tag, "_valid_drop"}, {31'd0, resp_valid}, 32'd0);
        chk({tag, "_idle"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        // ---------------- reset ----------------
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_flags", {30'd0, resp_misaligned, resp_illegal}, 32'd0);
        chk("rst_wmem", {31'd0, mem_write_mem}, 32'd0);
        chk("rst_addr", mem_write_address, 32'd0);
        chk("rst_wdata", mem_write_data, 32'd0);

        // ---------------- SW 0x104 ----------------
        do_req(1'b1, 3'b010, 32'h100, 32'd4, 32'hDEAD_BEEF, lat);
        chk("sw_latency", lat, 2);
        chk("sw_wr_cnt", wr_cnt, 1);
        chk("sw_wr_addr", wr_addr, 32'h104);
        chk("sw_flags", {30'd0, resp_misaligned, resp_illegal}, 32'd0);
        chk("sw_rdata", resp_rdata, 32'd0);
        finish_resp("sw");

        // ---------------- LW 0x104 ----------------
        do_req(1'b0, 3'b010, 32'h100, 32'd4, 32'd0, lat);
        chk("lw_latency", lat, 3);
        chk("lw_rdata", resp_rdata, 32'hDEAD_BEEF);
        chk("lw_flags", {30'd0, resp_misaligned, resp_illegal}, 32'd0);
        finish_resp("lw");

        // ---------------- SB 0x80 at 0x203, then LB / LBU ----------------
        do_req(1'b1, 3'b000, 32'h200, 32'd3, 32'h0000_0080, lat);
        chk("sb_latency", lat, 2);
        chk("sb_wr_cnt", wr_cnt, 2);
        finish_resp("sb");
        do_req(1'b0, 3'b000, 32'h200, 32'd3, 32'd0, lat);
        chk("lb_rdata", resp_rdata, 32'hFFFF_FF80);
        finish_resp("lb");
        do_req(1'b0, 3'b100, 32'h200, 32'd3, 32'd0, lat);
        chk("lbu_rdata", resp_rdata, 32'h0000_0080);
        finish_resp("lbu");

        // ---------------- misaligned LW 0x102 / SH 0x101 ----------------
        do_req(1'b0, 3'b010, 32'h100, 32'd2, 32'd0, lat);
        chk("lw_mis_latency", lat, 1);
        chk("lw_mis_flags", {30'd0, resp_misaligned, resp_illegal}, 32'd2);
        chk("lw_mis_rdata", resp_rdata, 32'd0);
        finish_resp("lw_mis");
        do_req(1'b1, 3'b001, 32'h100, 32'd1, 32'h1234_5678, lat);
        chk("sh_mis_latency", lat, 1);
        chk("sh_mis_flags", {30'd0, resp_misaligned, resp_illegal}, 32'd2);
        chk("sh_mis_rdata", resp_rdata, 32'd0);
        chk("sh_mis_no_write", wr_cnt, 2);
        finish_resp("sh_mis");

        // ---------------- illegal funct3 / unmapped ----------------
        do_req(1'b0, 3'b011, 32'h100, 32'd0, 32'd0, lat);
        chk("f3_ill_latency", lat, 1);
        chk("f3_ill_flags", {30'd0, resp_misaligned, resp_illegal}, 32'd1);
        finish_resp("f3_ill");
        do_req(1'b1, 3'b110, 32'h100, 32'd0, 32'h0, lat);
        chk("st_f3_ill_flags", {30'd0, resp_misaligned, resp_illegal}, 32'd1);
        chk("st_f3_no_write", wr_cnt, 2);
        finish_resp("st_f3_ill");
        do_req(1'b0, 3'b010, 32'h0000_4000, 32'd0, 32'd0, lat);
        chk("unmap_latency", lat, 1);
        chk("unmap_flags", {30'd0, resp_misaligned, resp_illegal}, 32'd1);
        chk("unmap_rdata", resp_rdata, 32'd0);
        finish_resp("unmap");
        do_req(1'b0, 3'b010, 32'h0000_4000, 32'd2, 32'd0, lat);
        chk("both_flags", {30'd0, resp_misaligned, resp_illegal}, 32'd3);
        finish_resp("both");

        // ---------------- MMIO millis, negative offset ----------------
        do_req(1'b0, 3'b010, 32'd0, 32'hFFFF_FFF8, 32'd0, lat);
        chk("millis_latency", lat, 3);
        chk("millis_rdata", resp_rdata, C_MILLIS);
        chk("millis_flags", {30'd0, resp_misaligned, resp_illegal}, 32'd0);
        finish_resp("millis");

        // ---------------- backpressure ----------------
        do_req(1'b0, 3'b010, 32'h104, 32'd0, 32'd0, lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", {31'd0, resp_valid}, 32'd1);
            chk("bp_rdata", resp_rdata, 32'hDEAD_BEEF);
            chk("bp_flags", {30'd0, resp_misaligned, resp_illegal}, 32'd0);
            chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
        end
        finish_resp("bp");

        // ---------------- reset during the ISSUE cycle of a store ----------------
        do_req(1'b1, 3'b010, 32'h300, 32'd0, 32'hA5A5_A5A5, lat);
        chk("pre_wr_cnt", wr_cnt, 3);
        finish_resp("pre");
        @(negedge clk);
        req_valid  = 1'b1;
        req_store  = 1'b1;
        req_funct3 = 3'b010;
        req_base   = 32'h300;
        req_offset = 32'd0;
        req_wdata  = 32'h1122_3344;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("issue_wmem_armed", {31'd0, mem_write_mem}, 32'd1);
        reset = 1'b1;
        #1;
        chk("issue_wmem_killed", {31'd0, mem_write_mem}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("abort_no_resp", {31'd0, resp_valid}, 32'd0);
        end
        chk("abort_wr_cnt", wr_cnt, 3);
        do_req(1'b0, 3'b010, 32'h300, 32'd0, 32'd0, lat);
        chk("abort_mem_kept", resp_rdata, 32'hA5A5_A5A5);
        finish_resp("abort_lw");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
